// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase, approach and timer-state definitions for the traffic light path
//
// Phase encoding (3-bit): even = go, odd = amber; phase[2:1] is the approach index.
// Imported by traffic_phase_timer and by the downstream lamp controller.
package traffic_pkg;

  localparam logic [2:0] PH_E_GO    = 3'd0;
  localparam logic [2:0] PH_E_AMBER = 3'd1;
  localparam logic [2:0] PH_S_GO    = 3'd2;
  localparam logic [2:0] PH_S_AMBER = 3'd3;
  localparam logic [2:0] PH_W_GO    = 3'd4;
  localparam logic [2:0] PH_W_AMBER = 3'd5;
  localparam logic [2:0] PH_N_GO    = 3'd6;
  localparam logic [2:0] PH_N_AMBER = 3'd7;

  localparam logic [1:0] APP_E = 2'd0;
  localparam logic [1:0] APP_S = 2'd1;
  localparam logic [1:0] APP_W = 2'd2;
  localparam logic [1:0] APP_N = 2'd3;

  typedef enum logic [1:0] {
    ST_GO     = 2'd0,
    ST_AMBER  = 2'd1,
    ST_ALLRED = 2'd2
  } timer_state_e;

endpackage

// File: rtl/traffic_phase_timer.sv
// rtl/traffic_phase_timer.sv - vehicle-actuated phase timer feeding the four-approach light controller
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   en       in   timing enable; low freezes phase, cnt and state
//   veh_req  in   [3:0] vehicle presence per approach (E,S,W,N = bit 0..3)
//   phase    out  [2:0] current phase (even = go, odd = amber)
//   advance  out  one-cycle pulse in the first cycle of a new phase value
//   cnt      out  [CNT_W-1:0] cycles already spent in the current interval
//   all_red  out  high during the all-red clearance interval
//
// Build option: define ALL_RED_EN to insert an all-red clearance interval
// after every amber; otherwise all_red is tied low.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int MIN_GREEN     = 4,
  parameter int MAX_GREEN     = 10,
  parameter int AMBER_CYCLES  = 3,
  parameter int ALLRED_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       veh_req,
  output logic [2:0]       phase,
  output logic             advance,
  output logic [CNT_W-1:0] cnt,
  output logic             all_red
);

  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] AMBER_LAST  = CNT_W'(AMBER_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYCLES - 1);

  timer_state_e     state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             advance_q, advance_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_GO;
      phase_q   <= PH_E_GO;
      cnt_q     <= '0;
      advance_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      advance_q <= advance_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    advance_d = 1'b0;
    if (en) begin
      case (state_q)
        ST_GO: begin
          // Only the active approach's request can extend green.
          if ((cnt_q >= MIN_LAST && !veh_req[phase_q[2:1]]) || cnt_q == MAX_LAST) begin
            state_d   = ST_AMBER;
            phase_d   = phase_q + 3'd1;
            cnt_d     = '0;
            advance_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_AMBER: begin
          if (cnt_q == AMBER_LAST) begin
            cnt_d = '0;
`ifdef ALL_RED_EN
            // Phase stays on the amber value through clearance.
            state_d = ST_ALLRED;
`else
            state_d   = ST_GO;
            phase_d   = phase_q + 3'd1;
            advance_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_ALLRED: begin
          if (cnt_q == ALLRED_LAST) begin
            state_d   = ST_GO;
            phase_d   = phase_q + 3'd1;
            cnt_d     = '0;
            advance_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_GO;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign phase   = phase_q;
  assign cnt     = cnt_q;
  assign advance = advance_q;

`ifdef ALL_RED_EN
  logic all_red_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      all_red_q <= 1'b0;
    end else begin
      all_red_q <= (state_d == ST_ALLRED);
    end
  end

  assign all_red = all_red_q;
`else
  assign all_red = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb/tb_traffic_phase_timer.sv - scoreboard bench for traffic_phase_timer
module tb_traffic_phase_timer;

  localparam int CNT_W   = 8;
  localparam int GO_LEN  = 4;
  localparam int MAX_LEN = 10;
`ifdef ALL_RED_EN
  localparam int AR_LEN  = 2;
  localparam int AMB_LEN = 3 + 2;
`else
  localparam int AR_LEN  = 0;
  localparam int AMB_LEN = 3;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [3:0]       veh_req;
  logic [2:0]       phase;
  logic             advance;
  logic [CNT_W-1:0] cnt;
  logic             all_red;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] ph;
    int         len;
    int         ar;
  } exp_t;

  exp_t exp_q[$];

  traffic_phase_timer #(
    .CNT_W(CNT_W), .MIN_GREEN(4), .MAX_GREEN(10), .AMBER_CYCLES(3), .ALLRED_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .veh_req(veh_req),
    .phase(phase), .advance(advance), .cnt(cnt), .all_red(all_red)
  );

  always #5 clk = ~clk;

  // Expected entry: the phase that appears with advance, plus the length and
  // all-red count of the interval it ends.
  task automatic push_exp(input logic [2:0] ph, input int len, input int ar);
    exp_t e;
    e.ph = ph; e.len = len; e.ar = ar;
    exp_q.push_back(e);
  endtask

  // Lap from phase 1 onwards with no requests, ending on the return to phase 0.
  task automatic push_lap(input int first_go_len);
    push_exp(3'd1, first_go_len, 0);
    for (int p = 2; p <= 8; p++) begin
      push_exp(3'(p % 8), (p % 2 == 0) ? AMB_LEN : GO_LEN, (p % 2 == 0) ? AR_LEN : 0);
    end
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: timeout, %0d expected advances still pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_cnt(input logic [CNT_W-1:0] v, input string name);
    int n = 0;
    while (cnt != v && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (cnt != v) begin
      errors++;
      $display("FAIL %s: cnt=%0d, required %0d", name, cnt, v);
    end
  endtask

  task automatic check_state(input string name, input logic [2:0] ph, input logic [CNT_W-1:0] c,
                             input logic adv, input logic ar);
    checks++;
    if (phase !== ph || cnt !== c || advance !== adv || all_red !== ar) begin
      errors++;
      $display("FAIL %s: phase=%0d cnt=%0d advance=%0b all_red=%0b, required %0d %0d %0b %0b",
               name, phase, cnt, advance, all_red, ph, c, adv, ar);
    end
  endtask

  // Monitor: on every advance pulse, pop and compare against the scoreboard.
  initial begin : monitor
    int   len;
    int   ar;
    logic prev_adv;
    exp_t e;
    len = 0; ar = 0; prev_adv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        len = 0; ar = 0; prev_adv = 1'b0;
      end else if (advance) begin
        checks++;
        if (prev_adv) begin
          errors++;
          $display("FAIL adv_back2back: advance high two cycles in a row at phase %0d", phase);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_adv: advance at phase %0d with no expectation", phase);
        end else begin
          e = exp_q.pop_front();
          if (phase !== e.ph || cnt !== '0) begin
            errors++;
            $display("FAIL adv_phase: phase=%0d cnt=%0d, required phase %0d cnt 0", phase, cnt, e.ph);
          end
          checks++;
          if (len != e.len || ar != e.ar) begin
            errors++;
            $display("FAIL interval_len: before phase %0d len=%0d all_red=%0d, required %0d %0d",
                     e.ph, len, ar, e.len, e.ar);
          end
        end
        len = 1;
        ar  = all_red ? 1 : 0;
        prev_adv = 1'b1;
      end else begin
        len++;
        if (all_red) ar++;
        prev_adv = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; veh_req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset_state", 3'd0, '0, 1'b0, 1'b0);
    rst = 1'b0; en = 1'b1;

    // Free-running lap with no requests.
    push_lap(GO_LEN);
    wait_empty("lap_no_req");

    // East request held: green extends to the maximum.
    veh_req = 4'b0001;
    push_lap(MAX_LEN);
    wait_empty("lap_max_green");

    // East request dropped while cnt==6: exit on that edge.
    wait_cnt(8'd6, "reach_cnt6");
    veh_req = 4'b0000;
    push_exp(3'd1, 7, 0);
    push_exp(3'd2, AMB_LEN, AR_LEN);
    wait_empty("drop_req");

    // Freeze at phase 2, cnt 1 for five edges.
    check_state("pre_freeze", 3'd2, 8'd1, 1'b0, 1'b0);
    push_exp(3'd3, GO_LEN + 5, 0);
    push_exp(3'd4, AMB_LEN, AR_LEN);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_state("freeze", 3'd2, 8'd1, 1'b0, 1'b0);
    end
    en = 1'b1;
    wait_empty("after_freeze");

    // Reset in phase 4 at cnt 2.
    wait_cnt(8'd2, "reach_ph4_cnt2");
    check_state("pre_reset", 3'd4, 8'd2, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_state("async_reset", 3'd0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_exp(3'd1, GO_LEN, 0);
    push_exp(3'd2, AMB_LEN, AR_LEN);
    wait_empty("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
